// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: sync-byte hunter and pixel-frame sequencer between the UART
// receiver and the classifier pixel buffer. It also owns the receiver baud code
// and aborts frames that stall between bytes.
// Optional feature macro: FRAME_CSUM_EN. When defined, a trailing XOR checksum
// byte follows each frame and is verified before the frame is presented.
module uart_frame_ctrl #(
    parameter int unsigned PIXELS      = 784,
    parameter int unsigned ADDR_W      = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned TO_W        = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        baud_sel_cfg,
    output logic [2:0]        baud_set,
    input  logic [7:0]        rx_byte,
    input  logic              rx_done,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_data,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic              err_csum
);

    // Pixel counter is one bit wider so it can hold PIXELS itself.
    localparam int unsigned      CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(PIXELS);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_FLUSH,
`ifdef FRAME_CSUM_EN
        S_CHECK,
`endif
        S_HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  tcnt;
`ifdef FRAME_CSUM_EN
    logic [7:0]       csum;
`else
    assign err_csum = 1'b0;
`endif

    // Frame sequencer: state, counters and every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            baud_set    <= '0;
            pix_we      <= 1'b0;
            pix_addr    <= '0;
            pix_data    <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef FRAME_CSUM_EN
            csum        <= '0;
            err_csum    <= 1'b0;
`endif
        end else begin
            pix_we      <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
`ifdef FRAME_CSUM_EN
            err_csum    <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    baud_set <= baud_sel_cfg;
                    if (rx_done && rx_byte == SYNC_BYTE) begin
                        cnt   <= '0;
                        tcnt  <= '0;
                        busy  <= 1'b1;
                        state <= S_RECV;
`ifdef FRAME_CSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                S_RECV: begin
                    // Leave only after the final write has been presented.
                    if (cnt == CNT_END) begin
                        tcnt  <= '0;
`ifdef FRAME_CSUM_EN
                        state <= S_CHECK;
`else
                        state <= S_FLUSH;
`endif
                    end else if (rx_done) begin
                        pix_we   <= 1'b1;
                        pix_addr <= cnt[ADDR_W-1:0];
                        pix_data <= rx_byte;
                        cnt      <= cnt + CNT_W'(1);
                        tcnt     <= '0;
`ifdef FRAME_CSUM_EN
                        csum     <= csum ^ rx_byte;
`endif
                    end else if (tcnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
`ifdef FRAME_CSUM_EN
                S_CHECK: begin
                    if (rx_done) begin
                        if (rx_byte == csum) begin
                            state <= S_FLUSH;
                        end else begin
                            err_csum <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end else if (tcnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
`endif
                S_FLUSH: begin
                    frame_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (rx_done) begin
                        err_overrun <= 1'b1;
                    end
                    if (frame_ack) begin
                        frame_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed-sequence bench for uart_frame_ctrl with randomized pixel data and
// byte spacing, checked against a frame-level reference kept in arrays.
module tb_uart_frame_ctrl;

    localparam int unsigned PIXELS      = 784;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned TIMEOUT_CYC = 300;
    localparam int unsigned TO_W        = 9;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        baud_sel_cfg = 3'd0;
    logic [2:0]        baud_set;
    logic [7:0]        rx_byte = 8'h00;
    logic              rx_done = 1'b0;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        pix_data;
    logic              frame_valid;
    logic              frame_ack = 1'b0;
    logic              busy;
    logic              err_timeout;
    logic              err_overrun;
    logic              err_csum;

    uart_frame_ctrl #(
        .PIXELS(PIXELS), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .baud_sel_cfg(baud_sel_cfg), .baud_set(baud_set),
        .rx_byte(rx_byte), .rx_done(rx_done), .pix_we(pix_we), .pix_addr(pix_addr),
        .pix_data(pix_data), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun),
        .err_csum(err_csum)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_data [PIXELS];
    int   wr_addr_q [$];
    int   wr_data_q [$];
    int   last_we_cyc = 0;
    int   fv_rise_cyc = 0;
    int   to_cyc = 0;
    int   n_to = 0;
    int   n_ov = 0;
    int   n_cs = 0;
    logic fv_prev = 1'b0;
`ifdef FRAME_CSUM_EN
    logic [7:0] csum_flip = 8'h00;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Capture writes and event pulses away from the active edge.
    always @(negedge clk) begin
        if (pix_we) begin
            wr_addr_q.push_back(int'(pix_addr));
            wr_data_q.push_back(int'(pix_data));
            last_we_cyc = cyc;
        end
        if (err_timeout) begin
            n_to++;
            to_cyc = cyc;
        end
        if (err_overrun) n_ov++;
        if (err_csum) n_cs++;
        if (frame_valid && !fv_prev) fv_rise_cyc = cyc;
        fv_prev = frame_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One rx_done pulse, then 'gap' idle edges before the next byte can land.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        repeat (gap) step();
    endtask

    // Sync then npix bytes; mode 0 index pattern, 1 random, 2 all ones.
    // slow_idx gets the longest gap that must not time out.
    task automatic send_frame(input int mode, input int npix, input int slow_idx);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < npix; i++) begin
            case (mode)
                0:       exp_data[i] = 8'(i % 256);
                1:       exp_data[i] = 8'($urandom);
                default: exp_data[i] = 8'h01;
            endcase
            x = x ^ exp_data[i];
        end
        send_byte(8'hA5, 2);
        chk("busy_after_sync", busy, 1);
        for (int i = 0; i < npix; i++) begin
            if (i == slow_idx) send_byte(exp_data[i], TIMEOUT_CYC - 1);
            else               send_byte(exp_data[i], $urandom_range(1, 3));
        end
`ifdef FRAME_CSUM_EN
        if (npix == int'(PIXELS)) send_byte(x ^ csum_flip, 2);
`else
        if (x == 8'h00) x = 8'h00;
`endif
    endtask

    task automatic check_writes(input string tag, input int n);
        int bad;
        int m;
        bad = 0;
        m = (wr_addr_q.size() < n) ? wr_addr_q.size() : n;
        chk({tag, "_count"}, wr_addr_q.size(), n);
        for (int i = 0; i < m; i++)
            if (wr_addr_q[i] != i || wr_data_q[i] != int'(exp_data[i])) bad++;
        chk({tag, "_data_bad"}, bad, 0);
    endtask

    task automatic clear_caps();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
    endtask

    initial begin
        int ov0;
        // Reset values
        repeat (3) step();
        chk("rst_baud_set", baud_set, 0);
        chk("rst_pix_we", pix_we, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_err_overrun", err_overrun, 0);
        reset = 1'b0;
        step();

        // Junk before sync is ignored
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h5A, 2);
        repeat (2) step();
        chk("junk_no_writes", wr_addr_q.size(), 0);
        chk("junk_busy", busy, 0);

        // Frame 1: index pattern
        send_frame(0, PIXELS, -1);
        repeat (6) step();
        check_writes("frame1", PIXELS);
        chk("frame1_valid", frame_valid, 1);
        chk("frame1_busy", busy, 0);
`ifndef FRAME_CSUM_EN
        chk("frame1_fv_latency", fv_rise_cyc - last_we_cyc, 2);
`endif

        // Overrun in HOLD, baud frozen
        baud_sel_cfg = 3'd2;
        ov0 = n_ov;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 2);
        repeat (2) step();
        chk("overrun_count", n_ov - ov0, 3);
        chk("overrun_no_write", wr_addr_q.size(), PIXELS);
        chk("overrun_fv_held", frame_valid, 1);
        chk("hold_baud_frozen", baud_set, 0);
        ack_frame();
        chk("ack_fv_fall", frame_valid, 0);
        step();
        chk("idle_baud_loaded", baud_set, 2);

        // Frame 2: random data, then ack with a coincident byte
        clear_caps();
        send_frame(1, PIXELS, -1);
        repeat (6) step();
        check_writes("frame2", PIXELS);
        ov0 = n_ov;
        rx_byte = 8'($urandom);
        rx_done = 1'b1;
        frame_ack = 1'b1;
        step();
        rx_done = 1'b0;
        frame_ack = 1'b0;
        chk("ack_rx_fv_fall", frame_valid, 0);
        repeat (2) step();
        chk("ack_rx_overrun", n_ov - ov0, 1);
        chk("ack_rx_no_write", wr_addr_q.size(), PIXELS);

        // Timeout after 100 bytes; sync value mid-frame is plain data
        clear_caps();
        exp_data[10] = 8'hA5;
        send_byte(8'hA5, 2);
        for (int i = 0; i < 100; i++) begin
            if (i != 10) exp_data[i] = 8'($urandom);
            send_byte(exp_data[i], (i == 99) ? 0 : $urandom_range(1, 3));
        end
        repeat (TIMEOUT_CYC + 10) step();
        chk("timeout_pulses", n_to, 1);
        chk("timeout_latency", to_cyc - last_we_cyc, TIMEOUT_CYC);
        chk("timeout_busy", busy, 0);
        check_writes("partial", 100);

        // Frame 3 from addr 0, with one gap just inside the limit
        clear_caps();
        send_frame(1, PIXELS, 500);
        repeat (6) step();
        check_writes("frame3", PIXELS);
        chk("edge_gap_no_timeout", n_to, 1);
        chk("frame3_valid", frame_valid, 1);
        ack_frame();
        step();

        // Reset mid-frame
        clear_caps();
        send_frame(1, 400, -1);
        reset = 1'b1;
        repeat (2) step();
        chk("midrst_busy", busy, 0);
        chk("midrst_pix_we", pix_we, 0);
        chk("midrst_baud_set", baud_set, 0);
        chk("midrst_frame_valid", frame_valid, 0);
        reset = 1'b0;
        step();
        check_writes("prerst", 400);
        clear_caps();
        send_frame(1, PIXELS, -1);
        repeat (6) step();
        check_writes("frame4", PIXELS);
        chk("frame4_valid", frame_valid, 1);
        ack_frame();
        step();

`ifdef FRAME_CSUM_EN
        // Checksum good then bad on an all-ones frame
        clear_caps();
        csum_flip = 8'h00;
        send_frame(2, PIXELS, -1);
        repeat (6) step();
        chk("csum_ok_valid", frame_valid, 1);
        chk("csum_ok_no_err", n_cs, 0);
        ack_frame();
        step();
        clear_caps();
        csum_flip = 8'h01;
        send_frame(2, PIXELS, -1);
        repeat (6) step();
        chk("csum_bad_err", n_cs, 1);
        chk("csum_bad_no_valid", frame_valid, 0);
        chk("csum_bad_busy", busy, 0);
`else
        chk("no_csum_err", n_cs, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Sequencer between the UART byte receiver and the pixel buffer that feeds the digit classifier. It hunts for a sync byte, then counts a fixed number of pixel bytes and writes them to consecutive buffer addresses. It then presents a completed frame to the inference engine and holds it until acknowledged. It also owns the receiver's baud selection and aborts stalled frames on an inter-byte timeout.

Parameters:
PIXELS, 784, pixel bytes per frame (28x28)
ADDR_W, 10, pixel buffer address width; 2^ADDR_W >= PIXELS
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 2000000, max clk cycles between bytes inside a frame (40 ms at 50 MHz)
TO_W, 21, timeout counter width; 2^TO_W > TIMEOUT_CYC

Ports:
clk  in  1  single system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
baud_sel_cfg  in  3  requested baud code (0=9600 ... 4)
baud_set  out  3  baud code driven to receiver
rx_byte  in  8  received byte, valid when rx_done=1
rx_done  in  1  one-cycle pulse per received byte
pix_we  out  1  pixel buffer write strobe
pix_addr  out  ADDR_W  pixel buffer write address
pix_data  out  8  pixel buffer write data
frame_valid  out  1  complete frame in buffer, level
frame_ack  in  1  consumer has finished with the frame
busy  out  1  high in RECV, FLUSH and CHECK
err_timeout  out  1  one-cycle pulse, frame aborted on gap
err_overrun  out  1  one-cycle pulse, byte dropped while in HOLD
err_csum  out  1  one-cycle pulse, checksum mismatch (feature only)

Behaviour:
- Reset: state=IDLE; all outputs 0 except baud_set=0; pixel count and timeout counter cleared. Reset mid-frame discards the partial frame. Buffer contents are not cleared.
- All outputs are registered.
- States: IDLE, RECV, FLUSH, CHECK (feature only), HOLD.
- IDLE: baud_set <= baud_sel_cfg every cycle, and only in IDLE. baud_set stays frozen in all other states. On rx_done with rx_byte==SYNC_BYTE: cnt<=0, tcnt<=0, go RECV. Other bytes are ignored silently.
- RECV: on rx_done, next cycle pix_we=1, pix_addr=cnt, pix_data=rx_byte (1-cycle latency). Then cnt++ and tcnt<=0. A byte equal to SYNC_BYTE is treated as data; there is no resync. When the byte written is cnt==PIXELS-1, go FLUSH (or CHECK with feature).
- RECV timeout: tcnt increments each cycle without rx_done. At tcnt==TIMEOUT_CYC-1, err_timeout pulses and state goes to IDLE. If rx_done coincides with that cycle, rx_done wins and no timeout occurs.
- FLUSH: one cycle, no write. Then go HOLD with frame_valid=1. frame_valid therefore rises exactly 2 cycles after the final pix_we.
- HOLD: frame_valid held high. On frame_ack, frame_valid=0 next cycle and state goes to IDLE. rx_done in HOLD: byte dropped, err_overrun pulses next cycle, no write. Simultaneous frame_ack and rx_done: ack honoured, byte dropped, err_overrun pulses.
- frame_ack outside HOLD is ignored.
- pix_we never asserts outside RECV. Writes per frame are exactly PIXELS. Addresses run 0..PIXELS-1 in order, no wrap.

Optional Feature:
FRAME_CSUM_EN
- Defined: one extra byte follows the last pixel and is not written to the buffer. It must equal the XOR of all PIXELS pixel bytes. The running XOR is cleared on sync.
- After the last pixel, state goes to CHECK, which waits for the checksum byte under the same timeout rule.
- Match: go FLUSH, then HOLD as normal.
- Mismatch: err_csum pulses, frame_valid is not raised, state goes to IDLE.
- Undefined: no CHECK state, no checksum byte, err_csum tied 0.

Test Plan:
- baud_sel_cfg=0, send A5 then bytes 0..255,0.. (784 bytes) -> 784 pix_we, addr 0..783, data = byte index mod 256. frame_valid rises 2 cycles after last pix_we and stays high until frame_ack, then falls 1 cycle later.
- Send 00, FF, 5A, then A5 + 784 bytes -> no pix_we before the A5; first write at addr 0.
- Send A5 + 100 bytes, idle TIMEOUT_CYC cycles -> err_timeout single pulse, state IDLE. Next A5 frame writes from addr 0.
- Full frame, hold frame_ack=0, send 3 bytes -> err_overrun pulses 3 times, no pix_we, frame_valid stays 1. baud_sel_cfg changed to 2 during HOLD -> baud_set stays 0 until IDLE.
- Assert reset after 400 pixel bytes -> outputs return to reset values. Next A5 frame completes normally from addr 0.
- FRAME_CSUM_EN: frame of all 8'h01 with checksum 00 -> frame_valid. Same frame with checksum 01 -> err_csum pulse, no frame_valid.
